br_predict_resolve: RTL and testbench

Parametrised branch predictor and resolver for the 5-stage pipeline. It holds a table of 2^IDX_W 2-bit saturating counters, indexed by low PC bits, and returns a taken/not-taken prediction to IF. It evaluates branch conditions in EX against flopped ALU flags and trains the counters. It drives the flow-change/redirect decision for mispredicts and jumps, and keeps saturating branch and mispredict statistics.

---
 rtl/br_predict_resolve.sv | 115 +++++++++++
 tb/tb_br_predict_resolve.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/br_predict_resolve.sv
// Branch predictor/resolver: 2-bit saturating counter table indexed by low PC bits,
// EX-stage condition evaluation on flopped flags, redirect decision and statistics.
module br_predict_resolve #(
    parameter int IDX_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  pc_idx_IF,
    output logic              pred_taken_IF,
    input  logic              clk_z_ID_EX,
    input  logic              clk_nv_ID_EX,
    input  logic              zr,
    input  logic              ov,
    input  logic              neg,
    input  logic              br_instr_ID_EX,
    input  logic              jmp_imm_ID_EX,
    input  logic              jmp_reg_ID_EX,
    input  logic [2:0]        cc_ID_EX,
    input  logic [IDX_W-1:0]  pc_idx_ID_EX,
    input  logic              pred_taken_ID_EX,
    input  logic              stall_EX,
    output logic              zr_EX_DM,
    output logic              taken_EX,
    output logic              flow_change_ID_EX,
    output logic              redirect_target_EX,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mispred_count
);

    localparam int DEPTH = 1 << IDX_W;

    logic [1:0]        cnt_q [DEPTH];
    logic [1:0]        cnt_d [DEPTH];
    logic              zr_q, zr_d;
    logic              ov_q, ov_d;
    logic              neg_q, neg_d;
    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] mispred_count_q, mispred_count_d;

    logic cond;
    logic jump;
    logic mispred;
    logic train;
    logic [1:0] cnt_cur;

    // Conditions read only the flopped flags, so a same-cycle flag load is not seen.
    always_comb begin
        cond = 1'b0;
        case (cc_ID_EX)
            3'b000: cond = ~zr_q;
            3'b001: cond = zr_q;
            3'b010: cond = ~zr_q & ~neg_q;
            3'b011: cond = neg_q;
            3'b100: cond = zr_q | ~neg_q;
            3'b101: cond = neg_q | zr_q;
            3'b110: cond = ov_q;
            default: cond = 1'b1;
        endcase
    end

    assign taken_EX           = br_instr_ID_EX & cond;
    assign jump               = jmp_imm_ID_EX | jmp_reg_ID_EX;
    assign mispred            = br_instr_ID_EX & (taken_EX != pred_taken_ID_EX);
    assign flow_change_ID_EX  = jump | mispred;
    assign redirect_target_EX = jump | taken_EX;
    assign train              = br_instr_ID_EX & ~stall_EX;
    assign cnt_cur            = cnt_q[pc_idx_ID_EX];

    // Lookup reads the registered table: a same-cycle update is not bypassed.
    assign pred_taken_IF = cnt_q[pc_idx_IF][1];
    assign zr_EX_DM      = zr_q;
    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;

    always_comb begin
        zr_d            = clk_z_ID_EX  ? zr  : zr_q;
        ov_d            = clk_nv_ID_EX ? ov  : ov_q;
        neg_d           = clk_nv_ID_EX ? neg : neg_q;
        cnt_d           = cnt_q;
        br_count_d      = br_count_q;
        mispred_count_d = mispred_count_q;
        if (train) begin
            if (taken_EX && cnt_cur != 2'b11)
                cnt_d[pc_idx_ID_EX] = cnt_cur + 2'd1;
            else if (!taken_EX && cnt_cur != 2'b00)
                cnt_d[pc_idx_ID_EX] = cnt_cur - 2'd1;
            if (!(&br_count_q))
                br_count_d = br_count_q + STAT_W'(1);
            if (mispred && !(&mispred_count_q))
                mispred_count_d = mispred_count_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                cnt_q[i] <= 2'b01;
            zr_q            <= 1'b0;
            ov_q            <= 1'b0;
            neg_q           <= 1'b0;
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                cnt_q[i] <= cnt_d[i];
            zr_q            <= zr_d;
            ov_q            <= ov_d;
            neg_q           <= neg_d;
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

endmodule

// File: tb/tb_br_predict_resolve.sv
// Bench for br_predict_resolve: condition-code vector table plus hand sequences for
// training, saturation, flag timing, stall/jump and statistic saturation (STAT_W = 4 copy).
`timescale 1ns/1ps
module tb_br_predict_resolve;

    logic       clk = 1'b0;
    logic       run_clk = 1'b0;
    logic       rst;
    logic [3:0] pc_idx_IF;
    logic       pred_taken_IF, pred4;
    logic       clk_z_ID_EX, clk_nv_ID_EX, zr, ov, neg;
    logic       br_instr_ID_EX, jmp_imm_ID_EX, jmp_reg_ID_EX;
    logic [2:0] cc_ID_EX;
    logic [3:0] pc_idx_ID_EX;
    logic       pred_taken_ID_EX, stall_EX;
    logic       zr_EX_DM, taken_EX, flow_change_ID_EX, redirect_target_EX;
    logic       zr4, taken4, flow4, redir4;
    logic [15:0] br_count, mispred_count;
    logic [3:0]  br_count4, mispred_count4;

    int n_chk = 0;
    int n_pass = 0;
    int exp_br = 0;
    int exp_mis = 0;

    always #5 if (run_clk) clk = ~clk;

    br_predict_resolve #(.IDX_W(4), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .pc_idx_IF(pc_idx_IF), .pred_taken_IF(pred_taken_IF),
        .clk_z_ID_EX(clk_z_ID_EX), .clk_nv_ID_EX(clk_nv_ID_EX), .zr(zr), .ov(ov), .neg(neg),
        .br_instr_ID_EX(br_instr_ID_EX), .jmp_imm_ID_EX(jmp_imm_ID_EX), .jmp_reg_ID_EX(jmp_reg_ID_EX),
        .cc_ID_EX(cc_ID_EX), .pc_idx_ID_EX(pc_idx_ID_EX), .pred_taken_ID_EX(pred_taken_ID_EX),
        .stall_EX(stall_EX), .zr_EX_DM(zr_EX_DM), .taken_EX(taken_EX),
        .flow_change_ID_EX(flow_change_ID_EX), .redirect_target_EX(redirect_target_EX),
        .br_count(br_count), .mispred_count(mispred_count)
    );

    br_predict_resolve #(.IDX_W(4), .STAT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pc_idx_IF(pc_idx_IF), .pred_taken_IF(pred4),
        .clk_z_ID_EX(clk_z_ID_EX), .clk_nv_ID_EX(clk_nv_ID_EX), .zr(zr), .ov(ov), .neg(neg),
        .br_instr_ID_EX(br_instr_ID_EX), .jmp_imm_ID_EX(jmp_imm_ID_EX), .jmp_reg_ID_EX(jmp_reg_ID_EX),
        .cc_ID_EX(cc_ID_EX), .pc_idx_ID_EX(pc_idx_ID_EX), .pred_taken_ID_EX(pred_taken_ID_EX),
        .stall_EX(stall_EX), .zr_EX_DM(zr4), .taken_EX(taken4),
        .flow_change_ID_EX(flow4), .redirect_target_EX(redir4),
        .br_count(br_count4), .mispred_count(mispred_count4)
    );

    typedef struct packed {
        logic       clk_z, clk_nv, zr, neg, ov, br, jimm, jreg;
        logic [2:0] cc;
        logic [3:0] idx;
        logic       pred, stall, et, ef, er, use_p, ep;
    } vec_t;

    typedef struct packed {
        logic et, ef, er, use_p, ep;
    } exp_t;

    typedef struct packed {
        logic       zr, neg, ov;
        logic [2:0] cc;
        logic       br, jimm, jreg, pred, et, ef, er;
    } rec_t;

    exp_t sbq[$];
    rec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic vec_t bv(input logic [2:0] cc, input logic [3:0] idx, input logic pred,
                                input logic stall, input logic et, input logic ef, input logic er);
        vec_t v = '0;
        v.br = 1'b1; v.cc = cc; v.idx = idx; v.pred = pred; v.stall = stall;
        v.et = et; v.ef = ef; v.er = er;
        return v;
    endfunction

    function automatic vec_t lv(input logic z, input logic n, input logic o);
        vec_t v = '0;
        v.clk_z = 1'b1; v.clk_nv = 1'b1; v.zr = z; v.neg = n; v.ov = o;
        return v;
    endfunction

    task automatic clear_inputs();
        clk_z_ID_EX = 0; clk_nv_ID_EX = 0; zr = 0; ov = 0; neg = 0;
        br_instr_ID_EX = 0; jmp_imm_ID_EX = 0; jmp_reg_ID_EX = 0; cc_ID_EX = 0;
        pc_idx_ID_EX = 0; pred_taken_ID_EX = 0; stall_EX = 0;
    endtask

    // Entered and left at posedge+1; outputs are judged at the negedge in between.
    task automatic cycle(input vec_t v);
        exp_t e;
        clk_z_ID_EX = v.clk_z; clk_nv_ID_EX = v.clk_nv; zr = v.zr; neg = v.neg; ov = v.ov;
        br_instr_ID_EX = v.br; jmp_imm_ID_EX = v.jimm; jmp_reg_ID_EX = v.jreg;
        cc_ID_EX = v.cc; pc_idx_ID_EX = v.idx; pred_taken_ID_EX = v.pred; stall_EX = v.stall;
        sbq.push_back({v.et, v.ef, v.er, v.use_p, v.ep});
        @(negedge clk);
        if (sbq.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sbq.pop_front();
            chk("taken_EX", taken_EX, e.et);
            chk("flow_change", flow_change_ID_EX, e.ef);
            chk("redirect_target", redirect_target_EX, e.er);
            if (e.use_p) chk("pred_same_cycle", pred_taken_IF, e.ep);
        end
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_br"}, br_count, exp_br);
        chk({nm, "_mis"}, mispred_count, exp_mis);
        chk({nm, "_br4"}, br_count4, (exp_br > 15) ? 15 : exp_br);
        chk({nm, "_mis4"}, mispred_count4, (exp_mis > 15) ? 15 : exp_mis);
    endtask

    initial begin
        vec_t v;
        //            zr neg ov  cc     br ji jr pr  et ef er
        tbl[0]  = '{1'b0,1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[1]  = '{1'b1,1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b0,3'b001,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[3]  = '{1'b0,1'b0,1'b0,3'b010,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[4]  = '{1'b0,1'b1,1'b0,3'b010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[5]  = '{1'b0,1'b1,1'b0,3'b011,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[6]  = '{1'b0,1'b1,1'b0,3'b100,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[7]  = '{1'b0,1'b0,1'b0,3'b100,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[8]  = '{1'b1,1'b1,1'b0,3'b101,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[9]  = '{1'b0,1'b0,1'b0,3'b101,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[10] = '{1'b0,1'b0,1'b1,3'b110,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[11] = '{1'b0,1'b0,1'b0,3'b110,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[12] = '{1'b0,1'b0,1'b0,3'b111,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,1'b1};
        tbl[13] = '{1'b0,1'b0,1'b0,3'b111,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,1'b0,3'b000,1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0};
        tbl[15] = '{1'b0,1'b0,1'b0,3'b111,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1};
        tbl[16] = '{1'b0,1'b0,1'b0,3'b111,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1};
        tbl[17] = '{1'b1,1'b0,1'b0,3'b000,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,1'b1};
        tbl[18] = '{1'b1,1'b0,1'b0,3'b010,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[19] = '{1'b0,1'b0,1'b0,3'b011,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};

        // Reset with the clock parked: no edge has occurred yet.
        rst = 1'b1;
        pc_idx_IF = 0;
        clear_inputs();
        #1;
        for (int i = 0; i < 16; i++) begin
            pc_idx_IF = 4'(i);
            #1;
            chk($sformatf("reset_pred_%0d", i), pred_taken_IF, 0);
        end
        chk_stats("reset");
        chk("reset_zr", zr_EX_DM, 0);
        chk("reset_taken", taken_EX, 0);
        chk("reset_flow", flow_change_ID_EX, 0);
        chk("reset_redir", redirect_target_EX, 0);

        #2 rst = 1'b0;
        run_clk = 1'b1;
        @(posedge clk); #1;

        // Condition-code table; stall keeps the table and statistics untouched.
        for (int i = 0; i < 20; i++) begin
            cycle(lv(tbl[i].zr, tbl[i].neg, tbl[i].ov));
            v = '0;
            v.br = tbl[i].br; v.jimm = tbl[i].jimm; v.jreg = tbl[i].jreg;
            v.cc = tbl[i].cc; v.pred = tbl[i].pred; v.stall = 1'b1;
            v.et = tbl[i].et; v.ef = tbl[i].ef; v.er = tbl[i].er;
            cycle(v);
        end
        chk_stats("after_table");

        // Saturation up at idx 5: 01 -> 10 -> 11 -> 11, then back down.
        pc_idx_IF = 4'd5;
        v = bv(3'b111, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); v.use_p = 1'b1; v.ep = 1'b0;
        cycle(v); exp_br++; exp_mis++;
        chk("sat_pred_after_first", pred_taken_IF, 1);
        v = bv(3'b111, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1); v.use_p = 1'b1; v.ep = 1'b1;
        cycle(v); exp_br++;
        cycle(v); exp_br++;
        chk_stats("sat_up");
        cycle(lv(1'b0, 1'b0, 1'b0));
        cycle(bv(3'b001, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); exp_br++;
        chk("sat_down_11_to_10", pred_taken_IF, 1);
        cycle(bv(3'b001, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)); exp_br++;
        chk("sat_down_10_to_01", pred_taken_IF, 0);

        // Not-taken mispredict goes to the fall-through PC.
        cycle(lv(1'b1, 1'b0, 1'b0));
        cycle(bv(3'b000, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0)); exp_br++; exp_mis++;
        chk_stats("nt_mispred");

        // Flag load and branch in one cycle: branch sees the old zero flag.
        cycle(lv(1'b0, 1'b0, 1'b0));
        v = bv(3'b001, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); v.clk_z = 1'b1; v.zr = 1'b1;
        cycle(v);
        chk("flag_zr_loaded", zr_EX_DM, 1);
        cycle(bv(3'b001, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));

        // Stalled branch and lone jump leave table and statistics alone.
        cycle(bv(3'b111, 4'd5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1));
        chk("stall_pred5", pred_taken_IF, 0);
        chk_stats("stall");
        v = '0; v.jreg = 1'b1; v.idx = 4'd5; v.ef = 1'b1; v.er = 1'b1;
        cycle(v);
        chk("jump_pred5", pred_taken_IF, 0);
        chk_stats("jump");

        // Twenty mispredicts: the 4-bit copy pins at 15.
        for (int i = 0; i < 20; i++) begin
            cycle(bv(3'b111, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1));
            exp_br++; exp_mis++;
        end
        chk_stats("stat_sat");

        // Asynchronous reset mid-cycle clears the table and statistics at once.
        pc_idx_IF = 4'd9;
        #1 chk("pre_reset_pred9", pred_taken_IF, 1);
        #1 rst = 1'b1;
        #1;
        exp_br = 0; exp_mis = 0;
        chk("async_reset_pred9", pred_taken_IF, 0);
        chk_stats("async_reset");
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
